pfc_pwm_sequencer: RTL and testbench

PFC_PWM_SEQUENCER -- requirements
Module: pfc_pwm_sequencer

---
 rtl/pfc_pwm_sequencer_if.sv | 18 +
 rtl/pfc_pwm_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pfc_pwm_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pfc_pwm_sequencer_if.sv
// Duty-word update bus for the PFC PWM sequencer.
// Carries the three leg compare words and their capture strobe.
interface pfc_pwm_sequencer_if #(
  parameter int CNT_W = 12
);
  logic [CNT_W-1:0] duty_a;
  logic [CNT_W-1:0] duty_b;
  logic [CNT_W-1:0] duty_c;
  logic             duty_valid;

  modport master (
    output duty_a, duty_b, duty_c, duty_valid
  );

  modport slave (
    input duty_a, duty_b, duty_c, duty_valid
  );
endinterface

// File: rtl/pfc_pwm_sequencer.sv
// Three-leg center-aligned PWM sequencer for a PFC stage.
// Shadowed duties, per-leg dead time and IDLE/ARM/RUN/TRIP control.
module pfc_pwm_sequencer #(
  parameter int CNT_W  = 12,
  parameter int PERIOD = 2499,
  parameter int DT     = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               run,
  input  logic               fault,
  pfc_pwm_sequencer_if.slave duty_bus,
  output logic               UP_L1,
  output logic               DW_L1,
  output logic               UP_L2,
  output logic               DW_L2,
  output logic               UP_L3,
  output logic               DW_L3,
  output logic               ce_out,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    TRIP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PEAK  = CNT_W'(PERIOD);
  localparam logic [7:0]       DT_LD = 8'(DT);

  state_t           st;
  logic [1:0]       rst_q;
  logic [CNT_W-1:0] cnt;
  logic             dir_up;
  logic [CNT_W-1:0] din  [3];
  logic [CNT_W-1:0] nxt  [3];
  logic [CNT_W-1:0] pend [3];
  logic [CNT_W-1:0] act  [3];
  logic [7:0]       dtc  [3];
  logic [2:0]       ref_x;
  logic [2:0]       ref_q;
  logic [2:0]       ld_ref;
  logic [2:0]       up;
  logic [2:0]       dw;
  logic             live;
  logic             spin;
  logic             valley;
  logic             stop;

  assign din[0] = duty_bus.duty_a;
  assign din[1] = duty_bus.duty_b;
  assign din[2] = duty_bus.duty_c;

  assign live   = clk_enable && rst_q[1];
  assign spin   = (st == ARM) || (st == RUN);
  assign valley = spin && (cnt == '0);
  assign stop   = (st == RUN) && valley && !run;
  assign ce_out = clk_enable && valley;
  assign state  = st;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nxt[i]    = duty_bus.duty_valid ? din[i] : pend[i];
      ref_x[i]  = cnt < act[i];
      ld_ref[i] = nxt[i] != '0;
    end
  end

  // Release is delayed two edges so the first enabled edge is clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_q <= '0;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      cnt    <= '0;
      dir_up <= 1'b1;
    end else if (live) begin
      unique case (1'b1)
        fault: st <= TRIP;
        !fault && st == IDLE: if (run) st <= ARM;
        !fault && st == ARM:  if (valley) st <= RUN;
        !fault && st == RUN:  if (stop) st <= IDLE;
        !fault && st == TRIP: if (!run) st <= IDLE;
        default: st <= st;
      endcase
      if (!spin || fault || stop) begin
        cnt    <= '0;
        dir_up <= 1'b1;
      end else if (dir_up) begin
        if (cnt == PEAK) begin
          cnt    <= PEAK - 1'b1;
          dir_up <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt == '0) begin
        cnt    <= CNT_W'(1);
        dir_up <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else if (live) begin
      for (int i = 0; i < 3; i++) begin
        if (duty_bus.duty_valid) pend[i] <= din[i];
        if (valley) act[i] <= nxt[i];
      end
    end
  end

  // The ARM valley seeds each leg from its incoming duty, skipping dead time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up    <= '0;
      dw    <= '0;
      ref_q <= '0;
      for (int i = 0; i < 3; i++) dtc[i] <= '0;
    end else if (live) begin
      for (int i = 0; i < 3; i++) begin
        if (fault || stop || st == IDLE || st == TRIP) begin
          up[i]  <= 1'b0;
          dw[i]  <= 1'b0;
          dtc[i] <= '0;
        end else if (st == ARM) begin
          up[i]    <= valley && ld_ref[i];
          dw[i]    <= valley && !ld_ref[i];
          ref_q[i] <= ld_ref[i];
          dtc[i]   <= '0;
        end else if (ref_x[i] != ref_q[i]) begin
          up[i]    <= 1'b0;
          dw[i]    <= 1'b0;
          ref_q[i] <= ref_x[i];
          dtc[i]   <= DT_LD;
        end else if (dtc[i] == 8'd1) begin
          up[i]  <= ref_q[i];
          dw[i]  <= !ref_q[i];
          dtc[i] <= '0;
        end else if (dtc[i] != '0) begin
          dtc[i] <= dtc[i] - 8'd1;
        end
      end
    end
  end

  assign UP_L1 = up[0];
  assign DW_L1 = dw[0];
  assign UP_L2 = up[1];
  assign DW_L2 = dw[1];
  assign UP_L3 = up[2];
  assign DW_L3 = dw[2];

endmodule

// File: tb/tb_pfc_pwm_sequencer.sv
// Self-checking bench for pfc_pwm_sequencer (PERIOD=10, DT=2).
// Directed scenarios plus randomized duty traffic against a reference model.
`timescale 1ns/1ps
module tb_pfc_pwm_sequencer;
  localparam int CW  = 12;
  localparam int PER = 10;
  localparam int DTC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  logic       run;
  logic       fault;
  logic       UP_L1, DW_L1, UP_L2, DW_L2, UP_L3, DW_L3;
  logic       ce_out;
  logic [1:0] state;
  logic [5:0] gates;

  int checks   = 0;
  int failures = 0;

  pfc_pwm_sequencer_if #(.CNT_W(CW)) dbus ();

  pfc_pwm_sequencer #(
    .CNT_W (CW),
    .PERIOD(PER),
    .DT    (DTC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .run       (run),
    .fault     (fault),
    .duty_bus  (dbus.slave),
    .UP_L1     (UP_L1),
    .DW_L1     (DW_L1),
    .UP_L2     (UP_L2),
    .DW_L2     (DW_L2),
    .UP_L3     (UP_L3),
    .DW_L3     (DW_L3),
    .ce_out    (ce_out),
    .state     (state)
  );

  assign gates = {UP_L1, DW_L1, UP_L2, DW_L2, UP_L3, DW_L3};

  always #5 clk = ~clk;

  // Reference model: state, phase since ARM entry, duties, ref history.
  int m_st;
  int m_ph;
  int m_pend [3];
  int m_act  [3];
  bit m_up   [3];
  bit m_dw   [3];
  bit hist   [3][$];
  int cur_d  [3];
  bit cur_run;

  function automatic int tri_wave(input int ph);
    int m;
    m = ph % (2 * PER);
    return (m <= PER) ? m : 2 * PER - m;
  endfunction

  function automatic int m_carrier();
    return (m_st == 1 || m_st == 2) ? tri_wave(m_ph) : 0;
  endfunction

  function automatic logic [5:0] m_gates();
    return {m_up[0], m_dw[0], m_up[1], m_dw[1], m_up[2], m_dw[2]};
  endfunction

  function automatic bit steady(input int i);
    for (int k = 1; k < hist[i].size(); k++)
      if (hist[i][k] != hist[i][0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_ph = 0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0;
      m_act[i]  = 0;
      m_up[i]   = 1'b0;
      m_dw[i]   = 1'b0;
      hist[i].delete();
    end
  endtask

  // A gate is on only when its ref held steady over the last DT+1 samples
  // (or since RUN began); otherwise the leg is in dead time.
  task automatic model_edge();
    int c;
    int ns;
    bit sp;
    bit vl;
    bit r [3];
    int nx [3];
    if (!clk_enable) return;
    sp = (m_st == 1 || m_st == 2);
    c  = m_carrier();
    vl = sp && c == 0;
    for (int i = 0; i < 3; i++) begin
      r[i]  = c < m_act[i];
      nx[i] = dbus.duty_valid ? cur_d[i] : m_pend[i];
    end
    if (fault) ns = 3;
    else case (m_st)
      0:       ns = run ? 1 : 0;
      1:       ns = vl ? 2 : 1;
      2:       ns = (vl && !run) ? 0 : 2;
      default: ns = run ? 3 : 0;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (ns == 2 && m_st == 1) begin
        hist[i].delete();
        hist[i].push_back(nx[i] != 0);
      end else if (ns == 2) begin
        hist[i].push_back(r[i]);
        if (hist[i].size() > DTC + 1) void'(hist[i].pop_front());
      end else begin
        hist[i].delete();
      end
      m_up[i] = 1'b0;
      m_dw[i] = 1'b0;
      if (ns == 2 && steady(i)) begin
        m_up[i] = hist[i][$];
        m_dw[i] = !hist[i][$];
      end
      if (dbus.duty_valid) m_pend[i] = cur_d[i];
      if (vl) m_act[i] = nx[i];
    end
    m_ph = (sp && (ns == 1 || ns == 2)) ? m_ph + 1 : 0;
    m_st = ns;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit rn, input bit flt, input bit dv,
                      input int a, input int b, input int c);
    clk_enable       = en;
    run              = rn;
    fault            = flt;
    dbus.duty_valid  = dv;
    dbus.duty_a      = CW'(a);
    dbus.duty_b      = CW'(b);
    dbus.duty_c      = CW'(c);
    cur_d[0] = a;
    cur_d[1] = b;
    cur_d[2] = c;
    cur_run  = rn;
    #1;
    check("ce_out", 16'(ce_out),
          16'(en && (m_st == 1 || m_st == 2) && m_carrier() == 0));
    @(posedge clk);
    model_edge();
    #1;
    check("state", 16'(state), 16'(m_st));
    check("gates", 16'(gates), 16'(m_gates()));
    check("overlap", 16'(gates & (gates >> 1) & 6'b010101), 16'd0);
  endtask

  task automatic hold(input int n);
    repeat (n) step(1'b1, cur_run, 1'b0, 1'b0, cur_d[0], cur_d[1], cur_d[2]);
  endtask

  task automatic sync_to(input int v);
    for (int k = 0; k < 2 * PER + 1; k++) begin
      if ((m_st == 1 || m_st == 2) && m_carrier() == v) break;
      hold(1);
    end
  endtask

  task automatic measure(input int leg, output int nu, output int nd,
                         output int nl);
    int ub;
    int db;
    ub = 7 - 2 * leg;
    db = 6 - 2 * leg;
    nu = 0;
    nd = 0;
    nl = 0;
    for (int k = 0; k < 2 * PER; k++) begin
      hold(1);
      if (gates[ub]) nu++;
      if (gates[db]) nd++;
      if (!gates[ub] && !gates[db]) nl++;
    end
  endtask

  initial begin
    int nu, nd, nl, big;
    model_reset();
    reset           = 1'b0;
    clk_enable      = 1'b1;
    run             = 1'b0;
    fault           = 1'b0;
    dbus.duty_valid = 1'b0;
    dbus.duty_a     = '0;
    dbus.duty_b     = '0;
    dbus.duty_c     = '0;
    cur_run = 1'b0;
    cur_d   = '{0, 0, 0};
    #2;
    check("rst_state", 16'(state), 16'd0);
    check("rst_gates", 16'(gates), 16'd0);
    check("rst_ce", 16'(ce_out), 16'd0);

    // run already high at release: first edge must stay in IDLE
    #10;
    run   = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("sync_idle", 16'(state), 16'd0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);

    // leg 1 at duty 5
    step(1, 0, 0, 1, 5, 3, 8);
    step(1, 1, 0, 0, 5, 3, 8);
    check("arm_entry", 16'(state), 16'd1);
    step(1, 1, 0, 0, 5, 3, 8);
    check("run_entry", 16'(state), 16'd2);
    check("direct_start", 16'(gates), 16'b101010);
    hold(40);
    measure(1, nu, nd, nl);
    check("d5_up", 16'(nu), 16'd7);
    check("d5_dw", 16'(nd), 16'd9);
    check("d5_gap", 16'(nl), 16'd4);

    // two strobes before one valley: only the last one lands
    sync_to(5);
    step(1, 1, 0, 1, 5, 3, 8);
    hold(2);
    step(1, 1, 0, 1, 5, 7, 8);
    hold(40);
    measure(2, nu, nd, nl);
    check("shadow_up", 16'(nu), 16'd11);
    check("shadow_gap", 16'(nl), 16'd4);

    // single-sample ref pulse restarts dead time
    step(1, 1, 0, 1, 1, 7, 8);
    hold(40);
    measure(1, nu, nd, nl);
    check("restart_up", 16'(nu), 16'd0);
    check("restart_dw", 16'(nd), 16'd17);
    check("restart_gap", 16'(nl), 16'd3);

    // saturation
    step(1, 1, 0, 1, 1, 7, 0);
    hold(40);
    measure(3, nu, nd, nl);
    check("sat0_dw", 16'(nd), 16'd20);
    check("sat0_gap", 16'(nl), 16'd0);
    step(1, 1, 0, 1, 1, 7, PER + 1);
    hold(40);
    measure(3, nu, nd, nl);
    check("sat11_up", 16'(nu), 16'd20);
    check("sat11_gap", 16'(nl), 16'd0);
    big = int'($urandom_range(4095, PER + 1));
    step(1, 1, 0, 1, 1, 7, big);
    hold(40);
    measure(3, nu, nd, nl);
    check("satbig_up", 16'(nu), 16'd20);

    // strobe on the valley itself
    sync_to(0);
    step(1, 1, 0, 1, 2, 7, 0);
    hold(40);
    measure(1, nu, nd, nl);
    check("valley_up", 16'(nu), 16'd1);
    check("valley_dw", 16'(nd), 16'd15);

    // clock-enable freeze on a valley
    sync_to(0);
    repeat (5) begin
      step(0, 1, 0, 0, 2, 7, 0);
      check("ce_frozen", 16'(ce_out), 16'd0);
    end
    hold(3);

    // fault, sticky trip, clear
    hold(7);
    step(1, 1, 1, 0, 2, 7, 0);
    check("trip_state", 16'(state), 16'd3);
    check("trip_gates", 16'(gates), 16'd0);
    repeat (4) begin
      step(1, 1, 0, 0, 2, 7, 0);
      check("trip_hold", 16'(state), 16'd3);
    end
    step(1, 0, 0, 0, 2, 7, 0);
    check("trip_clear", 16'(state), 16'd0);

    // graceful stop
    step(1, 1, 0, 0, 5, 7, 0);
    step(1, 1, 0, 0, 5, 7, 0);
    hold(33);
    for (int k = 0; k < 2 * PER + 2 && m_st != 0; k++)
      step(1, 0, 0, 0, 5, 7, 0);
    check("stop_state", 16'(state), 16'd0);
    check("stop_gates", 16'(gates), 16'd0);

    // random duty traffic
    for (int k = 0; k < 400; k++) begin
      bit en;
      bit dv;
      int ra, rb, rc;
      en = ($urandom % 16) != 0;
      dv = ($urandom % 6) == 0;
      ra = dv ? int'($urandom_range(PER + 2, 0)) : cur_d[0];
      rb = dv ? int'($urandom_range(PER + 2, 0)) : cur_d[1];
      rc = dv ? int'($urandom_range(PER + 2, 0)) : cur_d[2];
      step(en, 1, 0, dv, ra, rb, rc);
    end

    // asynchronous reset mid-RUN
    step(1, 1, 0, 1, 5, 7, 0);
    hold(30);
    check("pre_rst_dw3", 16'(DW_L3), 16'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_gates", 16'(gates), 16'd0);
    check("async_state", 16'(state), 16'd0);
    check("async_ce", 16'(ce_out), 16'd0);
    model_reset();
    #3;
    run   = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", 16'(state), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
